multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the LEGv8 datapath: replaces single-cycle decode with an FSM that steps

---
 rtl/multicycle_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_ctrl_if.sv | 13 +
 rtl/multicycle_ctrl_opclass.sv | 22 ++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle controller (package mc_pkg).
// Holds the state enum, opcode constants, ALU select encodings and the opcode class record.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_ADDR,
      S_MEMRD,
      S_WBLD,
      S_MEMWR,
      S_EXEC,
      S_WBR,
      S_BRANCH
   } state_t;

   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   // CBZ owns the whole 0x5A0..0x5A7 block; the low three bits carry part of the immediate.
   localparam logic [10:0] OP_CBZ  = 11'h5A0;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef struct packed {
      logic is_ld;
      logic is_st;
      logic is_cbz;
      logic is_r;
      logic is_ill;
   } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the controller and the memory.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_ready;
   logic IorD;
   logic MemRead;
   logic MemWrite;

   modport master (output mem_req, output IorD, output MemRead, output MemWrite,
                   input mem_ready);
   modport slave  (input mem_req, input IorD, input MemRead, input MemWrite,
                   output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier; anything not recognised, including unknown bits, is illegal.
module mc_opclass
   import mc_pkg::*;
#(
   parameter int OP_W = 11
) (
   input  logic [OP_W-1:0] op,
   output opclass_t        cls
);

   always_comb begin
      cls = '0;
      casez (op)
         OP_LDUR:                          cls.is_ld  = 1'b1;
         OP_STUR:                          cls.is_st  = 1'b1;
         11'b101_1010_0???:                cls.is_cbz = 1'b1;
         OP_ADD, OP_SUB, OP_AND, OP_ORR:   cls.is_r   = 1'b1;
         default:                          cls.is_ill = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer: steps each instruction through fetch/decode/exec/mem/writeback.
// Optional MCCTRL_PERF_EN adds free-running cycle and retired-instruction counters.
//
// state    | meaning
// S_FETCH  | read instruction at PC, PC+4; leave on mem_ready
// S_DECODE | classify opcode, precompute branch target
// S_ADDR   | compute load/store address
// S_MEMRD  | data read at ALUOut, wait mem_ready
// S_WBLD   | write MDR into register file
// S_MEMWR  | data write at ALUOut, wait mem_ready
// S_EXEC   | R-type ALU operation
// S_WBR    | write ALU result into register file
// S_BRANCH | zero test, conditional PC update
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int OP_W = 11
`ifdef MCCTRL_PERF_EN
   ,
   parameter int PERF_W = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   Op,
   input  logic              zero,
   multicycle_ctrl_if.master mem,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              PCWriteCond,
   output logic              Reg2Loc,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ALUOp,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              illegal
`ifdef MCCTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instr_cnt
`endif
);

   state_t   state;
   state_t   state_nxt;
   opclass_t cls;

   logic mem_req;
   logic iord;
   logic mem_read;
   logic mem_write;

   // The zero flag is consumed by the datapath's PCWriteCond gate, not by sequencing.
   logic unused_zero;
   assign unused_zero = zero;

   mc_opclass #(.OP_W(OP_W)) u_opclass (
      .op  (Op),
      .cls (cls)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      mem_req     = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      Reg2Loc     = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      illegal     = 1'b0;

      // Outputs are held quiet while reset is asserted so an in-flight access drops at once.
      if (reset) begin
         case (state)
            S_FETCH: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               ALUSrcB  = SRCB_FOUR;
               if (mem.mem_ready) begin
                  IRWrite   = 1'b1;
                  PCWrite   = 1'b1;
                  state_nxt = S_DECODE;
               end
            end
            S_DECODE: begin
               ALUSrcB = SRCB_IMM_SH;
               Reg2Loc = cls.is_st | cls.is_cbz;
               if (cls.is_ld || cls.is_st) state_nxt = S_ADDR;
               else if (cls.is_r)          state_nxt = S_EXEC;
               else if (cls.is_cbz)        state_nxt = S_BRANCH;
               else begin
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
            S_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               if (cls.is_ld)      state_nxt = S_MEMRD;
               else if (cls.is_st) state_nxt = S_MEMWR;
               else                state_nxt = S_FETCH;
            end
            S_MEMRD: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               iord     = 1'b1;
               if (mem.mem_ready) state_nxt = S_WBLD;
            end
            S_WBLD: begin
               RegWrite  = 1'b1;
               MemtoReg  = 1'b1;
               state_nxt = S_FETCH;
            end
            S_MEMWR: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               iord      = 1'b1;
               Reg2Loc   = 1'b1;
               if (mem.mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_REG;
               ALUOp     = ALUOP_FUNCT;
               state_nxt = S_WBR;
            end
            S_WBR: begin
               RegWrite  = 1'b1;
               state_nxt = S_FETCH;
            end
            S_BRANCH: begin
               Reg2Loc     = 1'b1;
               ALUSrcA     = 1'b1;
               ALUSrcB     = SRCB_REG;
               ALUOp       = ALUOP_PASSB;
               PCWriteCond = 1'b1;
               state_nxt   = S_FETCH;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   assign mem.mem_req  = mem_req;
   assign mem.IorD     = iord;
   assign mem.MemRead  = mem_read;
   assign mem.MemWrite = mem_write;

`ifdef MCCTRL_PERF_EN
   logic retire;

   // Illegal opcodes return to fetch from decode and are deliberately not counted.
   assign retire = (state_nxt == S_FETCH) &&
                   ((state == S_WBLD) || (state == S_MEMWR) ||
                    (state == S_WBR)  || (state == S_BRANCH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (retire) instr_cnt <= instr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus a hand-written mid-access reset sequence.
module tb_multicycle_ctrl;
   import mc_pkg::*;

   // {mem_req,IorD,MemRead,MemWrite,IRWrite,PCWrite,PCWriteCond,Reg2Loc,ALUSrcA,ALUSrcB,ALUOp,MemtoReg,RegWrite,illegal}
   localparam logic [15:0] E_RST   = 16'h0000;
   localparam logic [15:0] E_FWAIT = 16'hA020;
   localparam logic [15:0] E_FRDY  = 16'hAC20;
   localparam logic [15:0] E_DEC   = 16'h0060;
   localparam logic [15:0] E_DECR2 = 16'h0160;
   localparam logic [15:0] E_DECIL = 16'h0061;
   localparam logic [15:0] E_ADDR  = 16'h00C0;
   localparam logic [15:0] E_MEMRD = 16'hE000;
   localparam logic [15:0] E_WBLD  = 16'h0006;
   localparam logic [15:0] E_MEMWR = 16'hD100;
   localparam logic [15:0] E_EXEC  = 16'h0090;
   localparam logic [15:0] E_WBR   = 16'h0002;
   localparam logic [15:0] E_BR    = 16'h0388;

   typedef struct {
      logic [10:0] op;
      logic        zero;
      logic        rdy;
      logic [15:0] exp;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [10:0] Op;
   logic        zero;
   logic        IRWrite, PCWrite, PCWriteCond, Reg2Loc, ALUSrcA, MemtoReg, RegWrite, illegal;
   logic [1:0]  ALUSrcB, ALUOp;

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   multicycle_ctrl_if mem_bus ();

   multicycle_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .Op          (Op),
      .zero        (zero),
      .mem         (mem_bus.master),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .Reg2Loc     (Reg2Loc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] outs();
      return {mem_bus.mem_req, mem_bus.IorD, mem_bus.MemRead, mem_bus.MemWrite,
              IRWrite, PCWrite, PCWriteCond, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
              MemtoReg, RegWrite, illegal};
   endfunction

   task automatic check(input string name, input int idx, input logic [15:0] exp);
      logic [15:0] act;
      act = outs();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
      end
   endtask

   // Called at posedge+1: drive, compare mid-cycle, advance to next posedge+1.
   task automatic apply(input string name, input int idx, input logic [10:0] op_v,
                        input logic z, input logic rdy, input logic [15:0] exp);
      Op                = op_v;
      zero              = z;
      mem_bus.mem_ready = rdy;
      #4;
      check(name, idx, exp);
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic [10:0] op_v, input logic z, input logic rdy,
                               input logic [15:0] exp);
      vec_t v;
      v.op = op_v; v.zero = z; v.rdy = rdy; v.exp = exp;
      vecs.push_back(v);
   endfunction

   function automatic void add_rtype(input logic [10:0] op_v);
      add(op_v, 1'b0, 1'b1, E_FRDY);
      add(op_v, 1'b0, 1'b1, E_DEC);
      add(op_v, 1'b0, 1'b1, E_EXEC);
      add(op_v, 1'b0, 1'b1, E_WBR);
   endfunction

   initial begin
      reset             = 1'b0;
      Op                = 11'h000;
      zero              = 1'b0;
      mem_bus.mem_ready = 1'b0;

      // fetch stall
      add(11'h000, 1'b0, 1'b0, E_FWAIT);
      add(11'h000, 1'b0, 1'b0, E_FWAIT);
      // LDUR zero-wait: 5 cycles
      add(11'h7C2, 1'b0, 1'b1, E_FRDY);
      add(11'h7C2, 1'b0, 1'b1, E_DEC);
      add(11'h7C2, 1'b0, 1'b1, E_ADDR);
      add(11'h7C2, 1'b0, 1'b1, E_MEMRD);
      add(11'h7C2, 1'b0, 1'b1, E_WBLD);
      // STUR with three wait cycles in MEMWR
      add(11'h7C0, 1'b0, 1'b1, E_FRDY);
      add(11'h7C0, 1'b0, 1'b1, E_DECR2);
      add(11'h7C0, 1'b0, 1'b1, E_ADDR);
      add(11'h7C0, 1'b0, 1'b0, E_MEMWR);
      add(11'h7C0, 1'b0, 1'b0, E_MEMWR);
      add(11'h7C0, 1'b0, 1'b0, E_MEMWR);
      add(11'h7C0, 1'b0, 1'b1, E_MEMWR);
      // CBZ taken
      add(11'h5A0, 1'b1, 1'b1, E_FRDY);
      add(11'h5A0, 1'b1, 1'b1, E_DECR2);
      add(11'h5A0, 1'b1, 1'b1, E_BR);
      // R-types
      add_rtype(11'h458);
      add_rtype(11'h658);
      add_rtype(11'h450);
      add_rtype(11'h550);
      // illegal opcode
      add(11'h000, 1'b0, 1'b1, E_FRDY);
      add(11'h000, 1'b0, 1'b1, E_DECIL);
      // top of CBZ block, zero clear
      add(11'h5A7, 1'b0, 1'b1, E_FRDY);
      add(11'h5A7, 1'b0, 1'b1, E_DECR2);
      add(11'h5A7, 1'b0, 1'b1, E_BR);
      // just past CBZ block
      add(11'h5A8, 1'b0, 1'b1, E_FRDY);
      add(11'h5A8, 1'b0, 1'b1, E_DECIL);
      add(11'h7FF, 1'b0, 1'b1, E_FRDY);
      add(11'h7FF, 1'b0, 1'b1, E_DECIL);
      // LDUR with read wait states
      add(11'h7C2, 1'b0, 1'b1, E_FRDY);
      add(11'h7C2, 1'b0, 1'b1, E_DEC);
      add(11'h7C2, 1'b0, 1'b1, E_ADDR);
      add(11'h7C2, 1'b0, 1'b0, E_MEMRD);
      add(11'h7C2, 1'b0, 1'b0, E_MEMRD);
      add(11'h7C2, 1'b0, 1'b1, E_MEMRD);
      add(11'h7C2, 1'b0, 1'b1, E_WBLD);
      add(11'h7C2, 1'b0, 1'b0, E_FWAIT);

      #2;
      check("reset_state", 0, E_RST);
      @(posedge clk);
      #6 reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply("vec", i, vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].exp);

      // reset while a load read is stalled
      apply("rst_seq", 0, 11'h7C2, 1'b0, 1'b1, E_FRDY);
      apply("rst_seq", 1, 11'h7C2, 1'b0, 1'b1, E_DEC);
      apply("rst_seq", 2, 11'h7C2, 1'b0, 1'b1, E_ADDR);
      mem_bus.mem_ready = 1'b0;
      #4;
      check("rst_memrd_wait", 3, E_MEMRD);
      #1 reset = 1'b0;
      #1;
      check("rst_async_drop", 4, E_RST);
      mem_bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_held", 5, E_RST);
      reset = 1'b1;
      apply("rst_seq", 6, 11'h458, 1'b0, 1'b0, E_FWAIT);
      apply("rst_seq", 7, 11'h458, 1'b0, 1'b1, E_FRDY);
      apply("rst_seq", 8, 11'h458, 1'b0, 1'b1, E_DEC);
      apply("rst_seq", 9, 11'h458, 1'b0, 1'b1, E_EXEC);
      apply("rst_seq", 10, 11'h458, 1'b0, 1'b1, E_WBR);
      apply("rst_seq", 11, 11'h458, 1'b0, 1'b0, E_FWAIT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
